// File: rtl/multichannel_pattern_generator.sv
// Multichannel pattern generator: constant / ramp / square / LFSR samples streamed
// over a valid/ready port, one sample per cycle, with per-channel lanes.

module mpg_lane #(
  parameter int DATA_W = 16,
  parameter int CH     = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic              lvl_i,
  output logic [DATA_W-1:0] data_o
);
  localparam logic [DATA_W-1:0] K   = DATA_W'(CH);
  localparam logic              ODD = (CH % 2) == 1;

  logic [DATA_W-1:0] data_q, data_d, init_lfsr;

  assign init_lfsr = seed_i + K;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      case (mode_i)
        2'd0:    data_d = seed_i;
        2'd1:    data_d = seed_i + step_i * K;
        2'd2:    data_d = {DATA_W{lvl_i ^ ODD}};
        default: data_d = (init_lfsr == '0) ? DATA_W'(1) : init_lfsr;
      endcase
    end else if (adv_i) begin
      case (mode_i)
        2'd0:    data_d = data_q;
        2'd1:    data_d = data_q + step_i;
        2'd2:    data_d = {DATA_W{lvl_i ^ ODD}};
        default: data_d = {data_q[DATA_W-2:0], data_q[DATA_W-1] ^ data_q[DATA_W-2]};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign data_o = data_q;
endmodule

module multichannel_pattern_generator #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int PER_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic [CNT_W-1:0]         num_samples,
  input  logic [PER_W-1:0]         half_period,
  input  logic [DATA_W-1:0]        step,
  input  logic [DATA_W-1:0]        seed,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         sample_idx,
  output logic                     busy,
  output logic                     done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  idx_q, idx_d, num_q, num_d;
  logic [1:0]        mode_q, mode_d;
  logic [PER_W-1:0]  hp_q, hp_d, sq_cnt_q, sq_cnt_d, eff_hp;
  logic [DATA_W-1:0] step_q, step_d, seed_q, seed_d;
  logic              lvl_q, lvl_d;
  logic              launch, last, adv;

  assign launch = (state_q == S_IDLE) && start && !abort;
  assign last   = (idx_q == num_q - CNT_W'(1));
  assign eff_hp = (hp_q == '0) ? PER_W'(1) : hp_q;
  assign adv    = (state_q == S_RUN) && vld_q && out_ready && !abort && !last;

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    idx_d    = idx_q;
    num_d    = num_q;
    mode_d   = mode_q;
    hp_d     = hp_q;
    step_d   = step_q;
    seed_d   = seed_q;
    sq_cnt_d = sq_cnt_q;
    lvl_d    = lvl_q;
    case (state_q)
      S_IDLE: if (launch) begin
        mode_d   = mode;
        num_d    = num_samples;
        hp_d     = half_period;
        step_d   = step;
        seed_d   = seed;
        idx_d    = '0;
        vld_d    = 1'b0;
        sq_cnt_d = '0;
        lvl_d    = 1'b0;
        state_d  = (num_samples == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        // first RUN cycle only primes the output register, so valid rises one edge later
        if (abort) begin
          vld_d   = 1'b0;
          state_d = S_IDLE;
        end else if (!vld_q) begin
          vld_d = 1'b1;
        end else if (out_ready) begin
          if (last) begin
            vld_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + CNT_W'(1);
            if (sq_cnt_q + PER_W'(1) == eff_hp) begin
              sq_cnt_d = '0;
              lvl_d    = ~lvl_q;
            end else begin
              sq_cnt_d = sq_cnt_q + PER_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      vld_q    <= 1'b0;
      idx_q    <= '0;
      num_q    <= '0;
      mode_q   <= '0;
      hp_q     <= '0;
      step_q   <= '0;
      seed_q   <= '0;
      sq_cnt_q <= '0;
      lvl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      mode_q   <= mode_d;
      hp_q     <= hp_d;
      step_q   <= step_d;
      seed_q   <= seed_d;
      sq_cnt_q <= sq_cnt_d;
      lvl_q    <= lvl_d;
    end
  end

  // lanes load from the live inputs on launch, then run from the latched copy
  logic [1:0]        lane_mode;
  logic [DATA_W-1:0] lane_seed, lane_step;
  assign lane_mode = launch ? mode : mode_q;
  assign lane_seed = launch ? seed : seed_q;
  assign lane_step = launch ? step : step_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    mpg_lane #(.DATA_W(DATA_W), .CH(k)) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .load_i (launch),
      .adv_i  (adv),
      .mode_i (lane_mode),
      .seed_i (lane_seed),
      .step_i (lane_step),
      .lvl_i  (lvl_d),
      .data_o (out_data[k*DATA_W +: DATA_W])
    );
  end

  assign out_valid  = vld_q;
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign sample_idx = idx_q;
endmodule

// File: tb/tb_multichannel_pattern_generator.sv
// Randomized bench for multichannel_pattern_generator against a formula-based model.

module tb_multichannel_pattern_generator;
  localparam int DW = 16, NCH = 4, CW = 32, PW = 16;

  logic              clk = 0, reset_n = 0, start = 0, abort = 0, out_ready = 0;
  logic [1:0]        mode = 0;
  logic [CW-1:0]     num_samples = 0;
  logic [PW-1:0]     half_period = 0;
  logic [DW-1:0]     step = 0, seed = 0;
  logic              out_valid, busy, done;
  logic [NCH*DW-1:0] out_data;
  logic [CW-1:0]     sample_idx;

  int checks = 0, errors = 0, xfers = 0;
  logic [NCH*DW-1:0] cap [0:15];

  multichannel_pattern_generator #(.DATA_W(DW), .NUM_CH(NCH), .CNT_W(CW), .PER_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .mode(mode),
    .num_samples(num_samples), .half_period(half_period), .step(step), .seed(seed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sample_idx(sample_idx), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] model(input int m, input int i, input logic [DW-1:0] sd,
                                               input logic [DW-1:0] st, input int hp);
    logic [NCH*DW-1:0] r;
    logic [DW-1:0] v;
    int eff, lv;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      case (m)
        0: v = sd;
        1: v = sd + DW'(i + k) * st;
        2: begin
          eff = (hp == 0) ? 1 : hp;
          lv  = (i / eff) % 2;
          v   = (((k % 2) ^ lv) != 0) ? {DW{1'b1}} : '0;
        end
        default: begin
          v = sd + DW'(k);
          if (v == '0) v = 1;
          repeat (i) v = {v[DW-2:0], v[DW-1] ^ v[DW-2]};
        end
      endcase
      r[k*DW +: DW] = v;
    end
    return r;
  endfunction

  task automatic scramble();
    mode        = 2'($urandom);
    num_samples = $urandom;
    half_period = PW'($urandom);
    step        = DW'($urandom);
    seed        = DW'($urandom);
    start       = ($urandom % 4) == 0;
  endtask

  task automatic run(input logic [1:0] m, input int n, input int hp, input logic [DW-1:0] sd,
                     input logic [DW-1:0] st, input int rdy_pct, input int abort_at);
    int ei, cyc;
    logic stalled;
    logic [NCH*DW-1:0] pdata;
    logic [CW-1:0] pidx;
    @(negedge clk);
    mode = m; num_samples = n; half_period = hp; seed = sd; step = st;
    start = 1; abort = 0; out_ready = 0;
    @(negedge clk);
    start = 0;
    scramble();
    start = 0;
    xfers = 0;
    if (n == 0) begin
      chk("zero_done", done, 1);
      chk("zero_vld", out_valid, 0);
      @(negedge clk);
      chk("zero_done_end", done, 0);
      chk("zero_vld_end", out_valid, 0);
      return;
    end
    chk("fill_vld", out_valid, 0);
    chk("fill_busy", busy, 1);
    @(negedge clk);
    ei = 0; cyc = 0; stalled = 0; pdata = '0; pidx = '0;
    while (ei < n && cyc < 2000) begin
      chk("vld", out_valid, 1);
      chk("idx", sample_idx, ei);
      chk("data", out_data, model(m, ei, sd, st, hp));
      if (stalled) begin
        chk("hold_idx", sample_idx, pidx);
        chk("hold_data", out_data, pdata);
      end
      if (ei < 16) cap[ei] = out_data;
      pidx = sample_idx; pdata = out_data;
      scramble();
      if (ei == abort_at) begin
        abort = 1; out_ready = 1'($urandom);
        @(negedge clk);
        abort = 0; start = 0;
        chk("ab_vld", out_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        @(negedge clk);
        chk("ab_done2", done, 0);
        chk("ab_vld2", out_valid, 0);
        return;
      end
      out_ready = ($urandom % 100) < rdy_pct;
      stalled = !out_ready;
      if (out_ready) begin ei++; xfers++; end
      @(negedge clk);
      cyc++;
    end
    chk("timeout", cyc < 2000, 1);
    chk("end_vld", out_valid, 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    start = 1; out_ready = 0;
    @(negedge clk);
    start = 0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_vld", out_valid, 0);
  endtask

  initial begin
    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", sample_idx, 0);
    chk("rst_data", out_data, 0);
    @(negedge clk);
    reset_n = 1;

    run(2'd1, 5, 0, 16'h0010, 16'd3, 100, -1);
    chk("ramp_s0", cap[0], 64'h0019_0016_0013_0010);
    chk("ramp_s1c0", cap[1][15:0], 16'h0013);
    chk("ramp_xfers", xfers, 5);

    run(2'd1, 3, 0, 16'hFFFE, 16'd1, 100, -1);
    chk("wrap_s0", cap[0], 64'h0001_0000_FFFF_FFFE);

    run(2'd2, 6, 2, 16'h0, 16'h0, 100, -1);
    chk("sq_s0", cap[0][31:0], 32'hFFFF_0000);
    chk("sq_s1", cap[1][31:0], 32'hFFFF_0000);
    chk("sq_s2", cap[2][31:0], 32'h0000_FFFF);
    chk("sq_s3", cap[3][31:0], 32'h0000_FFFF);
    run(2'd2, 4, 0, 16'h0, 16'h0, 100, -1);
    chk("sq0_s0", cap[0][15:0], 16'h0000);
    chk("sq0_s1", cap[1][15:0], 16'hFFFF);

    run(2'd3, 4, 0, 16'h0001, 16'h0, 100, -1);
    chk("lfsr_s0", cap[0][31:0], 32'h0002_0001);
    chk("lfsr_s1", cap[1][31:0], 32'h0004_0002);
    run(2'd3, 2, 0, 16'hFFFF, 16'h0, 100, -1);
    chk("lfsr_zero_fix", cap[0][31:16], 16'h0001);

    run(2'd0, 6, 0, 16'hA5C3, 16'h7, 100, -1);
    run(2'd1, 10, 0, 16'h1234, 16'h0101, 40, -1);
    chk("bp_xfers", xfers, 10);
    run(2'd1, 8, 0, 16'h0, 16'h1, 100, 2);
    run(2'd1, 0, 0, 16'h0, 16'h1, 100, -1);

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    mode = 1; num_samples = 4; start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("ab_st_busy", busy, 0);
    chk("ab_st_done", done, 0);
    @(negedge clk);
    chk("ab_st_vld", out_valid, 0);

    // reset in the middle of a run
    @(negedge clk);
    mode = 1; num_samples = 10; seed = 16'h4444; step = 16'h11; start = 1;
    @(negedge clk);
    start = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_idx", sample_idx, 0);
    chk("mrst_data", out_data, 0);
    @(negedge clk);
    chk("mrst_done_hold", done, 0);
    reset_n = 1; out_ready = 0;
    run(2'd1, 5, 0, 16'h0010, 16'd3, 100, -1);
    chk("pwrup_s0", cap[0], 64'h0019_0016_0013_0010);

    for (int r = 0; r < 10; r++) begin
      int m, n, ab;
      m  = $urandom % 4;
      n  = 1 + $urandom % 12;
      ab = (($urandom % 4) == 0) ? int'($urandom % n) : -1;
      run(2'(m), n, $urandom % 4, DW'($urandom), DW'($urandom), 30 + $urandom % 71, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multichannel_pattern_generator.md
MULTICHANNEL_PATTERN_GENERATOR -- requirements
Module: multichannel_pattern_generator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, per-channel sample width; legal range >= 4.
REQ-002 SHALL have parameter NUM_CH, default 4, number of output channels; legal range >= 1.
REQ-003 SHALL have parameter CNT_W, default 32, width of the sample counter and the sample count.
REQ-004 SHALL have parameter PER_W, default 16, width of the square-wave half-period.
REQ-005 SHALL have port clk, input, 1 bit, the single sampling clock for all logic.
REQ-006 SHALL have port reset_n, input, 1 bit, reset; asynchronous assertion, active-low.
REQ-007 SHALL have port start, input, 1 bit, pulse that launches a run.
REQ-008 SHALL have port abort, input, 1 bit, terminates a run.
REQ-009 SHALL have port mode, input, 2 bits: 0 constant, 1 ramp, 2 square, 3 LFSR.
REQ-010 SHALL have port num_samples, input, CNT_W bits, number of samples per run.
REQ-011 SHALL have port half_period, input, PER_W bits, square-wave half-period in samples.
REQ-012 SHALL have ports step and seed, input, DATA_W bits each: ramp increment, and initial value.
REQ-013 SHALL have port out_valid, output, 1 bit, sample available.
REQ-014 SHALL have port out_ready, input, 1 bit, sink accepts the sample.
REQ-015 SHALL have port out_data, output, NUM_CH*DATA_W bits; channel k occupies out_data[k*DATA_W +: DATA_W].
REQ-016 SHALL have port sample_idx, output, CNT_W bits, index of the presented sample.
REQ-017 SHALL have ports busy (high in RUN) and done (one-cycle pulse), output, 1 bit each.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-019 In IDLE, start=1 with abort=0 SHALL latch mode, num_samples, half_period, step and seed.
REQ-020 From that IDLE start, the FSM SHALL enter RUN, or enter DONE if num_samples==0.
REQ-021 The latched configuration SHALL stay in force for the whole run; input changes during RUN SHALL be ignored.
REQ-022 Latency: start sampled at edge N SHALL give out_valid=1, sample_idx=0 after edge N+1.
REQ-023 A sample SHALL transfer on any edge with out_valid&&out_ready.
REQ-024 While out_valid&&!out_ready, out_data and sample_idx SHALL hold stable; out_valid SHALL NOT drop except on abort.
REQ-025 Each transfer SHALL increment sample_idx and compute the next sample.
REQ-026 Back-to-back transfers SHALL sustain one sample per cycle.
REQ-027 The transfer with sample_idx==num_samples-1 SHALL end the run: out_valid=0 and state DONE next cycle.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 Mode 0 (constant): every channel SHALL output seed on every sample.
REQ-030 Mode 1 (ramp): sample i, channel k SHALL be (seed + (i+k)*step) mod 2^DATA_W, wrapping silently.
REQ-031 Mode 2 (square): level L = (i / max(half_period,1)) mod 2; half_period==0 SHALL behave as 1.
REQ-032 Mode 2 (square): even channels SHALL output all-zeros when L=0 and all-ones when L=1; odd channels SHALL output the inverse.
REQ-033 Mode 3 (LFSR): channel k SHALL initialise to (seed+k) mod 2^DATA_W, replaced by 1 if 0.
REQ-034 Mode 3 (LFSR): each transfer SHALL update every channel to next = {cur[DATA_W-2:0], cur[DATA_W-1]^cur[DATA_W-2]}.
REQ-035 Start during RUN or DONE SHALL be ignored.
REQ-036 Abort in RUN SHALL take effect next edge: IDLE, out_valid=0, done stays 0; a pending unaccepted sample SHALL be discarded.
REQ-037 Abort and start in the same IDLE cycle: abort SHALL win and no run SHALL start.
REQ-038 sample_idx SHALL reset to 0 at each start; num_samples up to 2^CNT_W-1 SHALL complete without counter wrap.

Reset
REQ-039 reset_n=0 SHALL asynchronously force IDLE, out_valid=0, busy=0, done=0, sample_idx=0, out_data=0 and all latched configuration to 0.
REQ-040 Reset mid-run SHALL abandon the run with no done pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-041 Ramp scenario: DATA_W=16, NUM_CH=4, seed=0x0010, step=3, num_samples=5, out_ready=1 -> sample0 ch0..3=0x0010,0x0013,0x0016,0x0019; sample1 ch0=0x0013; 5 transfers; done pulses one cycle after the 5th transfer.
REQ-042 Wrap-around scenario: ramp, seed=0xFFFE, step=1 -> sample0 ch0..3=0xFFFE,0xFFFF,0x0000,0x0001.
REQ-043 Square scenario: half_period=2 -> samples 0,1: ch0=0x0000, ch1=0xFFFF; samples 2,3: ch0=0xFFFF, ch1=0x0000. half_period=0 -> alternates every sample.
REQ-044 LFSR scenario: seed=0x0001 -> sample0 ch0=0x0001, ch1=0x0002; sample1 ch0=0x0002, ch1=0x0004. seed=0xFFFF -> ch1 initialises to 0x0001.
REQ-045 Backpressure scenario: out_ready toggled pseudo-randomly for 3 idle cycles -> out_data and sample_idx stable while stalled; no sample lost or duplicated.
REQ-046 Abort/reset scenario: abort at sample_idx=2 -> IDLE next cycle, no done pulse. num_samples=0 start -> done one cycle later, out_valid never 1. reset_n low mid-run -> all outputs 0 immediately.
